// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, colours, wall geometry and the
// wall renderer state encoding. The wall datapath uses the same geometry.
package game_pkg;

  localparam int unsigned SCREEN_W   = 160;
  localparam int unsigned SCREEN_H   = 120;
  localparam int unsigned WALL_WIDTH = 4;
  localparam int unsigned HOLE_H     = 50;

  localparam logic [2:0] WALL_COLOUR = 3'b010;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  // Renderer states. The state names the pixel being issued at the next
  // edge; the registered outputs show it one cycle later.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } render_state_t;

  // Keep the hole fully on screen: its top row may not exceed hole_max.
  function automatic logic [6:0] clamp_hole(input logic [6:0] hole,
                                            input logic [6:0] hole_max);
    return (hole > hole_max) ? hole_max : hole;
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// Column-major rectangle scanner: cy runs 0..HEIGHT-1 fastest, cx steps
// when cy wraps. last flags the final pixel; one step past it wraps to 0.
module rect_scanner #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned HEIGHT = 120,
  parameter int unsigned CX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  parameter int unsigned CY_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            last
);

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(WIDTH - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(HEIGHT - 1);

  logic cy_wrap;

  // Wrap detection for the row counter and the whole rectangle.
  always_comb begin
    cy_wrap = (cy == CY_LAST);
    last    = cy_wrap && (cx == CX_LAST);
  end

  // Advance one pixel per go; reset returns to the top-left corner.
  always_ff @(posedge clk) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
    end else if (go) begin
      if (cy_wrap) begin
        cy <= '0;
        cx <= (cx == CX_LAST) ? '0 : cx + 1'b1;
      end else begin
        cy <= cy + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wall_renderer.sv
// Paints the wall into the VGA frame buffer each frame: erases the previous
// wall column block (if any), then draws the new one with a hole repainted
// in background colour. One pixel per cycle, all outputs registered.
//
// Handshake: start is a one-cycle request taken only in IDLE when the done
// pulse is not showing; busy is high from the cycle after acceptance through
// the done cycle, and done pulses for one cycle when the frame is written.
module wall_renderer #(
  parameter int unsigned WALL_WIDTH  = game_pkg::WALL_WIDTH,
  parameter int unsigned HOLE_H      = game_pkg::HOLE_H,
  parameter int unsigned SCREEN_W    = game_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H    = game_pkg::SCREEN_H,
  parameter logic [2:0]  WALL_COLOUR = game_pkg::WALL_COLOUR,
  parameter logic [2:0]  BG_COLOUR   = game_pkg::BG_COLOUR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              wall_x,
  input  logic [6:0]              hole_y,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [2:0]              vga_colour,
  output logic                    vga_plot,
  output game_pkg::render_state_t state_dbg
);

  import game_pkg::*;

  localparam int unsigned CX_W = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;
  localparam int unsigned CY_W = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [6:0]  HOLE_MAX = 7'(SCREEN_H - HOLE_H);

  render_state_t   state, state_nxt;
  logic [7:0]      cur_x;
  logic [6:0]      cur_hole;
  logic [7:0]      prev_x;
  logic            prev_valid;

  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic            scan_last;
  logic            scan_go;

  // Issue-side signals describing the pixel registered at the next edge.
  logic            accept;
  logic            finish;
  logic            pix_valid;
  logic            pix_draw;
  logic [7:0]      pix_base;
  logic [6:0]      pix_hole;
  logic [6:0]      hole_clamped;
  logic [8:0]      col_sum;
  logic [7:0]      hole_end;
  logic            in_hole;
  logic            on_screen;
  logic [2:0]      pix_colour;

  assign state_dbg = state;

  rect_scanner #(
    .WIDTH  (WALL_WIDTH),
    .HEIGHT (SCREEN_H),
    .CX_W   (CX_W),
    .CY_W   (CY_W)
  ) u_scanner (
    .clk   (clk),
    .reset (reset),
    .go    (scan_go),
    .cx    (cx),
    .cy    (cy),
    .last  (scan_last)
  );

  // Next-state logic and selection of the pixel to issue this cycle. The
  // first pixel of a frame is issued on the accepting edge straight from the
  // inputs so the first write is visible in the cycle after start.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    finish       = 1'b0;
    scan_go      = 1'b0;
    pix_valid    = 1'b0;
    pix_draw     = 1'b0;
    pix_base     = cur_x;
    pix_hole     = cur_hole;
    hole_clamped = clamp_hole(hole_y, HOLE_MAX);
    case (state)
      ST_IDLE: begin
        // done still high means this is the done cycle: starts are ignored.
        if (start && !done) begin
          accept    = 1'b1;
          scan_go   = 1'b1;
          pix_valid = 1'b1;
          pix_hole  = hole_clamped;
          if (prev_valid) begin
            state_nxt = ST_ERASE;
            pix_base  = prev_x;
          end else begin
            state_nxt = ST_DRAW;
            pix_draw  = 1'b1;
            pix_base  = wall_x;
          end
        end
      end
      ST_ERASE: begin
        scan_go   = 1'b1;
        pix_valid = 1'b1;
        pix_base  = prev_x;
        if (scan_last) state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        scan_go   = 1'b1;
        pix_valid = 1'b1;
        pix_draw  = 1'b1;
        if (scan_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pixel geometry: 9-bit column sum for clipping, hole band for colour.
  always_comb begin
    col_sum    = 9'(pix_base) + 9'(cx);
    on_screen  = (col_sum < 9'(SCREEN_W));
    hole_end   = {1'b0, pix_hole} + 8'(HOLE_H);
    in_hole    = (8'(cy) >= {1'b0, pix_hole}) && (8'(cy) < hole_end);
    pix_colour = BG_COLOUR;
    if (pix_draw && !in_hole) pix_colour = WALL_COLOUR;
  end

  // FSM state register plus the current/previous wall bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_x      <= '0;
      cur_hole   <= '0;
      prev_x     <= '0;
      prev_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cur_x    <= wall_x;
        cur_hole <= hole_clamped;
      end
      if (finish) begin
        prev_x     <= cur_x;
        prev_valid <= 1'b1;
      end
    end
  end

  // Registered outputs for the issued pixel and the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      busy     <= pix_valid | finish;
      done     <= finish;
      vga_plot <= pix_valid & on_screen;
      if (pix_valid) begin
        vga_x      <= col_sum[7:0];
        vga_y      <= 7'(cy);
        vga_colour <= pix_colour;
      end else begin
        vga_x      <= '0;
        vga_y      <= '0;
        vga_colour <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wall_renderer.sv
// Bench for wall_renderer: a frame-level model lists every expected pixel
// write, a monitor checks each plotted pixel against that list in order,
// and the driver checks busy/done timing and the start/reset behaviour.
module tb_wall_renderer;

  localparam int SW       = 160;
  localparam int SH       = 120;
  localparam int WW       = 4;
  localparam int HH       = 50;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLACK = 3'b000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  wall_x;
  logic [6:0]  hole_y;
  logic        busy;
  logic        done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  game_pkg::render_state_t state_dbg;

  int checks = 0;
  int errors = 0;
  int plot_cnt = 0;

  logic [17:0] exp_q[$];

  int m_prev_valid = 0;
  int m_prev_x = 0;

  wall_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .wall_x     (wall_x),
    .hole_y     (hole_y),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .state_dbg  (state_dbg)
  );

  // Clock and run-time guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference model: every write of one frame, in scan order.
  function automatic int push_frame(input int x, input int hy);
    int hole;
    int cnt;
    logic [2:0] col;
    cnt = 0;
    hole = (hy > SH - HH) ? SH - HH : hy;
    if (m_prev_valid != 0) begin
      for (int c = 0; c < WW; c++)
        for (int y = 0; y < SH; y++)
          if (m_prev_x + c < SW) begin
            exp_q.push_back({8'(m_prev_x + c), 7'(y), BLACK});
            cnt++;
          end
    end
    for (int c = 0; c < WW; c++)
      for (int y = 0; y < SH; y++)
        if (x + c < SW) begin
          col = (y >= hole && y < hole + HH) ? BLACK : GREEN;
          exp_q.push_back({8'(x + c), 7'(y), col});
          cnt++;
        end
    return cnt;
  endfunction

  // Monitor: each plotted pixel must be the next expected write.
  always @(negedge clk) begin
    logic [17:0] got;
    logic [17:0] want;
    if (vga_plot === 1'b1) begin
      got = {vga_x, vga_y, vga_colour};
      plot_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x=%0d y=%0d colour=%0d, expected no write",
                 vga_x, vga_y, vga_colour);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d colour=%0d, expected x=%0d y=%0d colour=%0d",
                   got[17:10], got[9:3], got[2:0], want[17:10], want[9:3], want[2:0]);
        end
      end
    end
  end

  // Called at #1 after an edge; drive start in the same slot.
  task automatic run_frame(input int x, input int hy, input int abort_at);
    int exp_done;
    int exp_cnt;
    bit seen;
    exp_cnt  = push_frame(x, hy);
    exp_done = (m_prev_valid != 0) ? 961 : 481;
    plot_cnt = 0;
    wall_x   = 8'(x);
    hole_y   = 7'(hy);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen  = 0;
    for (int n = 1; n <= 1100; n++) begin
      if (n == abort_at) begin
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_plot", vga_plot, 0);
        check("abort_vga", {vga_x, vga_y, vga_colour}, 0);
        check("abort_state", state_dbg, game_pkg::ST_IDLE);
        reset = 1'b0;
        exp_q.delete();
        m_prev_valid = 0;
        return;
      end
      check("busy_active", busy, 1);
      if (done === 1'b1) begin
        check("done_cycle", n, exp_done);
        check("done_plot", vga_plot, 0);
        seen = 1;
        break;
      end
      // Stray start pulses while busy must have no effect.
      start = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 1100 cycles, expected cycle %0d", exp_done);
    end
    // A start in the done cycle is ignored.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_done", busy, 0);
    check("done_pulse_width", done, 0);
    check("frame_writes", plot_cnt, exp_cnt);
    check("pending_writes", exp_q.size(), 0);
    m_prev_valid = 1;
    m_prev_x = x;
  endtask

  // Stimulus sequence.
  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    wall_x = '0;
    hole_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_plot", vga_plot, 0);
    check("reset_vga", {vga_x, vga_y, vga_colour}, 0);
    check("reset_state", state_dbg, game_pkg::ST_IDLE);
    reset = 1'b0;

    run_frame(100, 30, 0);
    run_frame(96, 40, 0);
    run_frame(158, 10, 0);
    run_frame(252, 20, 0);
    run_frame(50, 100, 0);
    run_frame(0, 127, 0);
    for (int i = 0; i < 4; i++)
      run_frame($urandom_range(0, 255), $urandom_range(0, 127), 0);
    // Reset at draw cycle 200 of an erase+draw frame.
    run_frame(30, 60, 680);
    run_frame(120, 5, 0);
    for (int i = 0; i < 2; i++)
      run_frame($urandom_range(0, 255), $urandom_range(0, 127), 0);

    repeat (3) @(posedge clk);
    #1;
    check("idle_end_busy", busy, 0);
    check("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
